// File: rtl/uart_fifo_bus_ctrl.sv
// UART bus front-end: register file, TX/RX FIFOs, TX start handshake, irq.
// Ports: clk_i/rst_i, bus (cs_i/we_i/adr_i/dat_i/dat_o/ack_o), irq_o,
// transmitter (send_start_o/send_data_o/busy_i/tc_i), receiver
// (rc_i/pe_i/receive_data_i), config outputs uart_brr_o/uart_cr_o.
module uart_fifo_bus_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cs_i,
    input  logic                 we_i,
    input  logic [31:0]          adr_i,
    input  logic [31:0]          dat_i,
    output logic [31:0]          dat_o,
    output logic                 ack_o,
    output logic                 irq_o,
    output logic                 send_start_o,
    output logic [DATA_BITS-1:0] send_data_o,
    input  logic                 busy_i,
    input  logic                 tc_i,
    input  logic                 rc_i,
    input  logic                 pe_i,
    input  logic [DATA_BITS-1:0] receive_data_i,
    output logic [15:0]          uart_brr_o,
    output logic [7:0]           uart_cr_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_BUSY} tx_state_e;

    tx_state_e state_q, state_d;
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic tc_q, tc_d, pe_q, pe_d, rxovr_q, rxovr_d, txovr_q, txovr_d;
    logic busy_q, flush_q, flush_d, ack_q, irq_q, irq_d;
    logic [6:0] cr_q, cr_d;
    logic [15:0] brr_q, brr_d;
    logic [31:0] dat_q, dat_d, rdata;
    logic [DATA_BITS-1:0] sdata_q, sdata_d;
    logic accept, wr, rd;
    logic [2:0] sel;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic unused_ok;

    assign unused_ok = ^{adr_i[31:5], adr_i[1:0], dat_i[31:16]};

    assign accept   = ~cs_i & ~ack_q;
    assign sel      = adr_i[4:2];
    assign wr       = accept & we_i;
    assign rd       = accept & ~we_i;
    assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    // Pops are held off during the flush cycle so nothing escapes a flush.
    assign tx_push  = wr & (sel == 3'd1) & ~tx_full;
    assign tx_pop   = (state_q == TX_IDLE) & cr_q[0] & ~tx_empty
                    & ~busy_i & ~flush_q;
    assign rx_push  = rc_i & cr_q[1] & ~rx_full;
    assign rx_pop   = rd & (sel == 3'd2) & ~rx_empty & ~flush_q;

    always_comb begin
        rdata = '0;
        unique case (sel)
            3'd0: rdata = {24'd0, txovr_q, rxovr_q, tx_empty, tx_full,
                           busy_q, pe_q, ~rx_empty, tc_q};
            3'd2: rdata = rx_pop ? 32'(rx_mem[rx_rd_q]) : 32'd0;
            3'd3: rdata = {16'd0, brr_q};
            3'd4: rdata = {25'd0, cr_q};
            3'd5: rdata = {16'd0, 8'(rx_cnt_q), 8'(tx_cnt_q)};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
        if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + 1'b1;
        if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
        if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
        if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + 1'b1;
        if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
        if (flush_q) begin
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            tx_cnt_d = '0;
            rx_wr_d  = '0;
            rx_rd_d  = '0;
            rx_cnt_d = '0;
        end
    end

    // Sticky flags: clear first, then set, so a same-cycle set wins.
    always_comb begin
        tc_d    = tc_q;
        pe_d    = pe_q;
        rxovr_d = rxovr_q;
        txovr_d = txovr_q;
        cr_d    = cr_q;
        brr_d   = brr_q;
        flush_d = 1'b0;
        if (wr && sel == 3'd0) begin
            tc_d    = tc_q & dat_i[0];
            pe_d    = pe_q & dat_i[2];
            rxovr_d = rxovr_q & dat_i[6];
            txovr_d = txovr_q & dat_i[7];
        end
        if (wr && sel == 3'd3 && !cr_q[0]) brr_d = dat_i[15:0];
        if (wr && sel == 3'd4) begin
            cr_d    = dat_i[6:0];
            flush_d = dat_i[7];
        end
        if (tc_i) tc_d = 1'b1;
        if (pe_i) pe_d = 1'b1;
        if (rc_i && cr_q[1] && rx_full) rxovr_d = 1'b1;
        if (wr && sel == 3'd1 && tx_full) txovr_d = 1'b1;
    end

    // irq tracks the state the registers take on at the same edge.
    always_comb begin
        irq_d = (tc_d & cr_d[2]) | (pe_d & cr_d[3])
              | ((rx_cnt_d != '0) & cr_d[4])
              | ((tx_cnt_d == '0) & cr_d[5])
              | ((rxovr_d | txovr_d) & cr_d[6]);
        dat_d = rd ? rdata : dat_q;
    end

    always_comb begin
        state_d = state_q;
        sdata_d = sdata_q;
        unique case (state_q)
            TX_IDLE: if (tx_pop) begin
                state_d = TX_START;
                sdata_d = tx_mem[tx_rd_q];
            end
            TX_START: if (busy_i) state_d = TX_BUSY;
            TX_BUSY:  if (!busy_i) state_d = TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_q] <= dat_i[DATA_BITS-1:0];
        if (rx_push) rx_mem[rx_wr_q] <= receive_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= TX_IDLE;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            tc_q     <= 1'b0;
            pe_q     <= 1'b0;
            rxovr_q  <= 1'b0;
            txovr_q  <= 1'b0;
            busy_q   <= 1'b0;
            flush_q  <= 1'b0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
            cr_q     <= '0;
            brr_q    <= '0;
            dat_q    <= '0;
            sdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            tc_q     <= tc_d;
            pe_q     <= pe_d;
            rxovr_q  <= rxovr_d;
            txovr_q  <= txovr_d;
            busy_q   <= busy_i;
            flush_q  <= flush_d;
            ack_q    <= ~cs_i;
            irq_q    <= irq_d;
            cr_q     <= cr_d;
            brr_q    <= brr_d;
            dat_q    <= dat_d;
            sdata_q  <= sdata_d;
        end
    end

    assign dat_o        = dat_q;
    assign ack_o        = ack_q;
    assign irq_o        = irq_q;
    assign send_start_o = (state_q == TX_START);
    assign send_data_o  = sdata_q;
    assign uart_brr_o   = brr_q;
    assign uart_cr_o    = {flush_q, cr_q};
endmodule

// File: tb/tb_uart_fifo_bus_ctrl.sv
// Self-checking bench for uart_fifo_bus_ctrl: register table, directed
// corner sequences and a randomized run against a queue-based model.
module tb_uart_fifo_bus_ctrl;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic cs_i = 1'b1;
    logic we_i = 1'b0;
    logic [31:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic ack_o, irq_o, send_start_o;
    logic [7:0] send_data_o;
    logic busy_i;
    logic tc_i = 1'b0;
    logic rc_i = 1'b0;
    logic pe_i = 1'b0;
    logic [7:0] receive_data_i = '0;
    logic [15:0] uart_brr_o;
    logic [7:0] uart_cr_o;

    logic hold_busy = 1'b0;
    logic xm_busy = 1'b0;
    int xm_t = 0;
    int starts = 0;
    logic prev_start = 1'b0;
    logic [7:0] sent_q[$];

    int checks = 0;
    int errors = 0;

    assign busy_i = xm_busy | hold_busy;

    always #5 clk = ~clk;

    uart_fifo_bus_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .cs_i(cs_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
        .irq_o(irq_o), .send_start_o(send_start_o),
        .send_data_o(send_data_o), .busy_i(busy_i), .tc_i(tc_i),
        .rc_i(rc_i), .pe_i(pe_i), .receive_data_i(receive_data_i),
        .uart_brr_o(uart_brr_o), .uart_cr_o(uart_cr_o)
    );

    // Transmitter stand-in: accepts a start, stays busy four cycles.
    always @(negedge clk) begin
        if (rst_i) begin
            xm_busy <= 1'b0;
        end else if (xm_busy) begin
            if (xm_t == 0) xm_busy <= 1'b0;
            else xm_t <= xm_t - 1;
        end else if (send_start_o && !hold_busy) begin
            xm_busy <= 1'b1;
            xm_t <= 3;
            sent_q.push_back(send_data_o);
        end
        if (send_start_o && !prev_start) starts <= starts + 1;
        prev_start <= send_start_o;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [2:0] a,
                       input logic [31:0] d, output logic [31:0] rdv);
        int n;
        @(negedge clk);
        cs_i = 1'b0;
        we_i = w;
        adr_i = {27'd0, a, 2'b00};
        dat_i = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_o && n < 8);
        if (!ack_o) chk("ack_timeout", 32'd0, 32'd1);
        rdv = dat_o;
        cs_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] x;
        bus(1'b1, a, d, x);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a,
                          input logic [31:0] exp);
        logic [31:0] x;
        bus(1'b0, a, 32'd0, x);
        chk(name, x, exp);
    endtask

    task automatic rc_pulse(input logic [7:0] d);
        @(negedge clk);
        rc_i = 1'b1;
        receive_data_i = d;
        @(negedge clk);
        rc_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        cs_i = 1'b1;
        rc_i = 1'b0;
        tc_i = 1'b0;
        pe_i = 1'b0;
        hold_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    // Reference model state for the randomized run.
    logic [7:0] m_rx[$];
    int m_tx;
    logic m_tc, m_pe, m_rxovr, m_txovr;

    function automatic logic [31:0] model_sr();
        return {24'd0, m_txovr, m_rxovr, (m_tx == 0), (m_tx == DEPTH),
                1'b0, m_pe, (m_rx.size() != 0), m_tc};
    endfunction

    initial begin
        logic [31:0] x;
        int n0, s0, n;
        logic [7:0] d8;
        logic [31:0] d32;

        vecs[0]  = '{1'b0, 3'd0, 32'h0, 32'h20};
        vecs[1]  = '{1'b0, 3'd5, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 3'd2, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 3'd1, 32'h0, 32'h0};
        vecs[4]  = '{1'b1, 3'd3, 32'hFFFF1234, 32'h0};
        vecs[5]  = '{1'b0, 3'd3, 32'h0, 32'h1234};
        vecs[6]  = '{1'b1, 3'd4, 32'h0000007E, 32'h0};
        vecs[7]  = '{1'b0, 3'd4, 32'h0, 32'h7E};
        vecs[8]  = '{1'b1, 3'd6, 32'hFFFFFFFF, 32'h0};
        vecs[9]  = '{1'b0, 3'd6, 32'h0, 32'h0};
        vecs[10] = '{1'b0, 3'd7, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 3'd4, 32'hFFFFFF00, 32'h0};
        vecs[12] = '{1'b0, 3'd4, 32'h0, 32'h0};
        vecs[13] = '{1'b0, 3'd3, 32'h0, 32'h1234};

        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        chk("rst_start", {31'd0, send_start_o}, 32'd0);
        chk("rst_sdata", {24'd0, send_data_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_cfg", {8'd0, uart_brr_o, uart_cr_o}, 32'd0);
        rst_i = 1'b0;

        // Handshake timing on a first SR read.
        @(negedge clk);
        cs_i = 1'b0;
        we_i = 1'b0;
        adr_i = 32'h0;
        chk("hs_ack_pre", {31'd0, ack_o}, 32'd0);
        @(negedge clk);
        chk("hs_ack_up", {31'd0, ack_o}, 32'd1);
        chk("hs_sr", dat_o, 32'h20);
        cs_i = 1'b1;
        @(negedge clk);
        chk("hs_ack_down", {31'd0, ack_o}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) wr(vecs[i].a, vecs[i].d);
            else rd_chk($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp);
        end

        // Reset in the middle of an access, cs held low across it.
        @(negedge clk);
        cs_i = 1'b0;
        we_i = 1'b0;
        adr_i = 32'h0;
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk("midrst_ack", {31'd0, ack_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("midrst_reack", {31'd0, ack_o}, 32'd1);
        chk("midrst_sr", dat_o, 32'h20);
        cs_i = 1'b1;
        @(negedge clk);

        // Three characters queued behind a busy transmitter.
        do_reset();
        hold_busy = 1'b1;
        wr(3'd4, 32'h01);
        wr(3'd1, 32'h41);
        wr(3'd1, 32'h42);
        wr(3'd1, 32'h43);
        rd_chk("tx_lvl3", 3'd5, 32'h0003);
        n0 = sent_q.size();
        s0 = starts;
        hold_busy = 1'b0;
        n = 0;
        while (sent_q.size() < n0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk("tx_count", sent_q.size() - n0, 32'd3);
        if (sent_q.size() >= n0 + 3)
            for (int i = 0; i < 3; i++)
                chk($sformatf("tx_char%0d", i), {24'd0, sent_q[n0 + i]},
                    32'h41 + i);
        chk("tx_starts", starts - s0, 32'd3);
        rd_chk("tx_lvl0", 3'd5, 32'h0);
        wr(3'd4, 32'h00);

        // RX overrun, drain to empty, then a long-held RDR read.
        do_reset();
        wr(3'd4, 32'h02);
        for (int i = 1; i <= DEPTH + 1; i++) rc_pulse(8'(i));
        rd_chk("rx_sr_ovr", 3'd0, 32'h62);
        rd_chk("rx_lvl_full", 3'd5, 32'h0800);
        for (int i = 1; i <= DEPTH; i++)
            rd_chk($sformatf("rx_rdr%0d", i), 3'd2, i);
        rd_chk("rx_rdr_empty", 3'd2, 32'h0);
        rd_chk("rx_sr_empty", 3'd0, 32'h60);
        rc_pulse(8'hA1);
        rc_pulse(8'hA2);
        rc_pulse(8'hA3);
        rd_chk("hold_lvl3", 3'd5, 32'h0300);
        @(negedge clk);
        cs_i = 1'b0;
        we_i = 1'b0;
        adr_i = 32'h8;
        repeat (5) @(negedge clk);
        chk("hold_data", dat_o, 32'hA1);
        cs_i = 1'b1;
        @(negedge clk);
        rd_chk("hold_lvl2", 3'd5, 32'h0200);

        // irq on TXE, then a sticky clear racing a tc pulse.
        do_reset();
        wr(3'd4, 32'h20);
        @(negedge clk);
        chk("irq_txe", {31'd0, irq_o}, 32'd1);
        @(negedge clk);
        cs_i = 1'b0;
        we_i = 1'b1;
        adr_i = 32'h4;
        dat_i = 32'h55;
        @(negedge clk);
        chk("irq_after_tdr", {31'd0, irq_o}, 32'd0);
        cs_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cs_i = 1'b0;
        we_i = 1'b1;
        adr_i = 32'h0;
        dat_i = 32'h0;
        tc_i = 1'b1;
        @(negedge clk);
        tc_i = 1'b0;
        cs_i = 1'b1;
        @(negedge clk);
        rd_chk("tc_set_wins", 3'd0, 32'h01);
        wr(3'd4, 32'h04);
        @(negedge clk);
        chk("irq_tc", {31'd0, irq_o}, 32'd1);

        // BRR lock under UE, and flush of partly filled FIFOs.
        do_reset();
        wr(3'd4, 32'h01);
        wr(3'd3, 32'h1234);
        chk("brr_locked", {16'd0, uart_brr_o}, 32'h0);
        wr(3'd4, 32'h00);
        wr(3'd3, 32'h1234);
        chk("brr_open", {16'd0, uart_brr_o}, 32'h1234);
        wr(3'd4, 32'h02);
        rc_pulse(8'h11);
        rc_pulse(8'h22);
        wr(3'd1, 32'h01);
        wr(3'd1, 32'h02);
        wr(3'd1, 32'h03);
        rd_chk("flush_pre", 3'd5, 32'h0203);
        wr(3'd4, 32'h82);
        rd_chk("flush_lvl", 3'd5, 32'h0);
        rd_chk("flush_cr", 3'd4, 32'h02);

        // Randomized traffic against the queue model (UE=0, RE=1).
        do_reset();
        wr(3'd4, 32'h02);
        m_rx.delete();
        m_tx = 0;
        m_tc = 1'b0;
        m_pe = 1'b0;
        m_rxovr = 1'b0;
        m_txovr = 1'b0;
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 7))
                0, 1: begin
                    d8 = 8'($urandom_range(0, 255));
                    rc_pulse(d8);
                    if (m_rx.size() < DEPTH) m_rx.push_back(d8);
                    else m_rxovr = 1'b1;
                end
                2: begin
                    wr(3'd1, $urandom);
                    if (m_tx < DEPTH) m_tx++;
                    else m_txovr = 1'b1;
                end
                3: begin
                    x = 32'd0;
                    if (m_rx.size() > 0) x = {24'd0, m_rx.pop_front()};
                    rd_chk("rnd_rdr", 3'd2, x);
                end
                4: rd_chk("rnd_lvl", 3'd5,
                          {16'd0, 8'(m_rx.size()), 8'(m_tx)});
                5: rd_chk("rnd_sr", 3'd0, model_sr());
                6: begin
                    d32 = $urandom;
                    wr(3'd0, d32);
                    m_tc = m_tc & d32[0];
                    m_pe = m_pe & d32[2];
                    m_rxovr = m_rxovr & d32[6];
                    m_txovr = m_txovr & d32[7];
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        wr(3'd4, 32'h82);
                        m_rx.delete();
                        m_tx = 0;
                    end else begin
                        @(negedge clk);
                        pe_i = 1'b1;
                        @(negedge clk);
                        pe_i = 1'b0;
                        m_pe = 1'b1;
                    end
                end
            endcase
        end
        rd_chk("rnd_final_sr", 3'd0, model_sr());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
